rams_sp_be_pipe_neg: RTL and testbench
======================================

# rams_sp_be_pipe_neg

Parametrised single-port RAM with negedge clocking, per-byte write enables, selectable read-during-write behaviour and an optional output pipeline stage with a valid flag. It is the generalised replacement for the fixed 1024x32 negedge single-port RAMs in the memory test suite. Storage maps onto block RAM, and the output register(s) reset asynchronously.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 10: address width.
- DEPTH, 2**ADDR_W: number of words; must be ≤ 2**ADDR_W.
- BYTE_W, 8: bits per write-enable lane; NB = DATA_W/BYTE_W.
- RDW_MODE, 0: read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 0 = one output register; 1 = one extra output pipeline register.
- RST_VAL, 0: DATA_W-bit value loaded into dout (and the pipeline register) on reset.

Ports:
- clk, input, 1: clock; all sequential logic on the falling edge.
- rst, input, 1: reset, asynchronous, active-high.
- we, input, NB: byte-lane write enables; bit i writes di[i*BYTE_W +: BYTE_W].
- re, input, 1: read enable.
- addr, input, ADDR_W: word address shared by read and write.
- di, input, DATA_W: write data.
- dout, output, DATA_W: read data.
- dout_valid, output, 1: high for one cycle when dout carries data from a new read.

## Operation
- Write: at each negedge with rst low, every lane with we[i]=1 updates RAM[addr] lane i. Other lanes are unchanged.
- Writes are blocked while rst is high. RAM contents are never reset.
- addr ≥ DEPTH: writes are ignored; reads return RST_VAL with dout_valid asserted.
- Read: at a negedge with re=1, the word at addr enters stage 1. With re=0, stage 1 holds its value and its valid bit clears.
- Read-during-write (re=1 and |we=1, always the same address):
  - READ_FIRST: returns the old word.
  - WRITE_FIRST: returns the merged word, with written lanes taking di and other lanes keeping the old data.
  - NO_CHANGE: stage 1 holds its data, its valid bit stays 0, and the write proceeds.
- OUT_REG=1: stage 2 copies the stage-1 data and valid bit at every negedge. dout and dout_valid come from stage 2.
- OUT_REG=0: dout and dout_valid come from stage 1.
- dout holds its last value between reads. dout_valid never stays high without a new read.

## Timing
- Reset values: dout = RST_VAL, dout_valid = 0, all stage registers = RST_VAL/0. Reset is asynchronous on rst rise, and outputs are released at the first negedge after rst falls.
- Read latency, counted from the negedge that samples re=1 until dout and dout_valid are updated:
  - OUT_REG=0: updated at that same negedge.
  - OUT_REG=1: updated one negedge later.
- Throughput: one access per cycle. Back-to-back reads produce a continuous dout_valid.
- Reset mid-pipeline: in-flight reads are discarded and no dout_valid is produced for them. The first read after reset follows normal latency.
- A write followed by a read of the same address on the next negedge returns the new data in every mode.

## Structure
- Package rams_pkg holds the RDW_MODE constants (RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE) and an elaboration-time check function for DATA_W % BYTE_W == 0.
- Sub-module rams_sp_be_core contains:
  - the storage array
  - the lane-masked write
  - the RDW mux
  - stage 1 (data and valid)
- The top level adds the optional stage 2, the out-of-range handling and the parameter assertions.

## Test plan
- Reset: assert rst mid-run with RST_VAL=32'hDEAD_BEEF. Required: dout = DEADBEEF and dout_valid = 0 immediately, without waiting for a clock edge; a read at addr 5 after release returns the previously written data.
- Byte lanes: write 32'h11223344 to addr 3, then write 32'hAABBCCDD with we=4'b0101. A read must return 32'h11BB33DD.
- RDW modes: RAM[7] = 32'h0, then re=1 and we=4'hF with di=32'h5A5A5A5A in one cycle. Required results:
  - READ_FIRST: dout = 0, valid = 1.
  - WRITE_FIRST: dout = 5A5A5A5A, valid = 1.
  - NO_CHANGE: dout holds, valid = 0.
  - All modes: a later read returns 5A5A5A5A.
- Latency: with OUT_REG=1, issue reads of addr 0..3 back-to-back. dout_valid is high for exactly 4 cycles, starting one negedge after the first read, with the data in order.
- Out of range: with DEPTH=1000 and ADDR_W=10, write then read addr 1010. The read returns RST_VAL with valid = 1, and addr 1010 mod 1000 = 10 is unchanged.

Source files
------------

// File: rtl/rams_pkg.sv
// ---------------------------------------------------------------------------
// rams_pkg
// Shared constants and elaboration helpers for the parametrised single-port
// byte-enable RAM family.
//   RDW_READ_FIRST  : a read that hits the word being written returns old data
//   RDW_WRITE_FIRST : the read returns the merged (old + written lanes) word
//   RDW_NO_CHANGE   : the read output is left untouched during a write
// ---------------------------------------------------------------------------
package rams_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // True when the data word splits evenly into write-enable lanes.
  function automatic bit byte_w_ok(input int data_w, input int byte_w);
    return (byte_w > 0) && ((data_w % byte_w) == 0);
  endfunction

endpackage

// File: rtl/rams_sp_be_core.sv
// ---------------------------------------------------------------------------
// rams_sp_be_core
// Storage array, lane-masked write, read-during-write mux and the first
// output stage (data + valid) of the single-port byte-enable RAM.
// All sequential logic runs on the falling clock edge.
// Ports:
//   clk_i      : clock (falling edge active)
//   rst_i      : asynchronous active-high reset of the stage-1 registers
//   we_i       : per-lane write enables, already cleared for blocked writes
//   re_i       : read enable
//   oor_i      : current address is beyond the populated depth
//   addr_i     : word address shared by read and write
//   di_i       : write data
//   rd_data_o  : stage-1 read data
//   rd_valid_o : stage-1 valid, one cycle per new read
// ---------------------------------------------------------------------------
module rams_sp_be_core
  import rams_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 2 ** ADDR_W,
  parameter int                BYTE_W   = 8,
  parameter int                RDW_MODE = RDW_READ_FIRST,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  localparam int               NB       = DATA_W / BYTE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB-1:0]     we_i,
  input  logic              re_i,
  input  logic              oor_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] di_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] oldWord;
  logic [DATA_W-1:0] mergedWord;
  logic              wrAny;

  logic [DATA_W-1:0] rdData_d, rdData_q;
  logic              rdValid_d, rdValid_q;

  assign oldWord = mem[addr_i];
  assign wrAny   = |we_i;

  // Word as it will look after this edge's write: written lanes take di.
  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < NB; i++) begin
      if (we_i[i]) begin
        mergedWord[i*BYTE_W +: BYTE_W] = di_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Storage has no reset so it maps cleanly onto block RAM.
  always_ff @(negedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (we_i[i]) begin
        mem[addr_i][i*BYTE_W +: BYTE_W] <= di_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Out-of-range reads win over everything else because no write can hit them.
  // In NO_CHANGE a colliding read leaves the data register alone and
  // produces no valid.
  always_comb begin
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;
    if (re_i) begin
      if (oor_i) begin
        rdData_d  = RST_VAL;
        rdValid_d = 1'b1;
      end else if (!((RDW_MODE == RDW_NO_CHANGE) && wrAny)) begin
        rdData_d  = (RDW_MODE == RDW_WRITE_FIRST) ? mergedWord : oldWord;
        rdValid_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdData_q  <= RST_VAL;
      rdValid_q <= 1'b0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rd_data_o  = rdData_q;
  assign rd_valid_o = rdValid_q;

endmodule

// File: rtl/rams_sp_be_pipe_neg.sv
// ---------------------------------------------------------------------------
// rams_sp_be_pipe_neg
// Parametrised negedge single-port RAM with byte-lane write enables,
// selectable read-during-write behaviour and an optional extra output stage.
// Ports:
//   clk        : clock, all sequential logic on the falling edge
//   rst        : asynchronous active-high reset of the output registers
//   we         : byte-lane write enables (NB = DATA_W/BYTE_W bits)
//   re         : read enable
//   addr       : word address shared by read and write
//   di         : write data
//   dout       : read data, holds between reads
//   dout_valid : high for one cycle per new read result
// ---------------------------------------------------------------------------
module rams_sp_be_pipe_neg
  import rams_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 2 ** ADDR_W,
  parameter int                BYTE_W   = 8,
  parameter int                RDW_MODE = 0,
  parameter int                OUT_REG  = 0,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  localparam int               NB       = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB-1:0]     we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (!byte_w_ok(DATA_W, BYTE_W)) begin : g_chk_byte_w
    $error("rams_sp_be_pipe_neg: DATA_W must be a multiple of BYTE_W");
  end
  if (DEPTH > 2 ** ADDR_W || DEPTH < 1) begin : g_chk_depth
    $error("rams_sp_be_pipe_neg: DEPTH must be in 1..2**ADDR_W");
  end
  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_chk_rdw
    $error("rams_sp_be_pipe_neg: RDW_MODE must be 0, 1 or 2");
  end
  if (OUT_REG < 0 || OUT_REG > 1) begin : g_chk_out_reg
    $error("rams_sp_be_pipe_neg: OUT_REG must be 0 or 1");
  end

  logic              oor;
  logic [NB-1:0]     weEff;
  logic [DATA_W-1:0] s1Data;
  logic              s1Valid;

  // Addresses past the populated depth never reach the array, and nothing
  // is written while reset is held.
  assign oor   = ({1'b0, addr} >= DEPTH_L);
  assign weEff = (oor || rst) ? '0 : we;

  rams_sp_be_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .BYTE_W  (BYTE_W),
    .RDW_MODE(RDW_MODE),
    .RST_VAL (RST_VAL)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (weEff),
    .re_i      (re),
    .oor_i     (oor),
    .addr_i    (addr),
    .di_i      (di),
    .rd_data_o (s1Data),
    .rd_valid_o(s1Valid)
  );

  if (OUT_REG != 0) begin : g_pipe
    logic [DATA_W-1:0] pipeData_q;
    logic              pipeValid_q;

    // Stage 2 copies stage 1 unconditionally; stage 1 already holds its data
    // between reads, so dout holds too.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        pipeData_q  <= RST_VAL;
        pipeValid_q <= 1'b0;
      end else begin
        pipeData_q  <= s1Data;
        pipeValid_q <= s1Valid;
      end
    end

    assign dout       = pipeData_q;
    assign dout_valid = pipeValid_q;
  end else begin : g_direct
    assign dout       = s1Data;
    assign dout_valid = s1Valid;
  end

endmodule

// File: tb/tb_rams_sp_be_pipe_neg.sv
// ---------------------------------------------------------------------------
// tb_rams_sp_be_pipe_neg
// Four instances share one stimulus stream:
//   dut0 READ_FIRST,  OUT_REG=0, DEPTH=1000
//   dut1 WRITE_FIRST, OUT_REG=0, DEPTH=1000
//   dut2 NO_CHANGE,   OUT_REG=0, DEPTH=1000
//   dut3 READ_FIRST,  OUT_REG=1, DEPTH=1024
// All use RST_VAL = 32'hDEAD_BEEF.
// ---------------------------------------------------------------------------
module tb_rams_sp_be_pipe_neg;

  localparam logic [31:0] RSTV = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       v;
  } exp_t;

  typedef struct packed {
    logic [3:0]  w;
    logic        r;
    logic [9:0]  a;
    logic [31:0] d;
  } stim_t;

  logic        clk;
  logic        rst;
  logic [3:0]  we;
  logic        re;
  logic [9:0]  addr;
  logic [31:0] di;

  logic [31:0] dout0, dout1, dout2, dout3;
  logic        val0, val1, val2, val3;
  logic [3:0][31:0] doutA;
  logic [3:0]       valA;

  assign doutA = {dout3, dout2, dout1, dout0};
  assign valA  = {val3, val2, val1, val0};

  int checks;
  int errors;

  exp_t        sbq[$];
  logic [3:0][31:0] s1d;
  logic [3:0]       s1v;
  logic [31:0] memS [1024];
  logic [31:0] memP [1024];

  rams_sp_be_pipe_neg #(.DEPTH(1000), .RDW_MODE(0), .OUT_REG(0), .RST_VAL(RSTV)) dut0 (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .di(di), .dout(dout0), .dout_valid(val0));
  rams_sp_be_pipe_neg #(.DEPTH(1000), .RDW_MODE(1), .OUT_REG(0), .RST_VAL(RSTV)) dut1 (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .di(di), .dout(dout1), .dout_valid(val1));
  rams_sp_be_pipe_neg #(.DEPTH(1000), .RDW_MODE(2), .OUT_REG(0), .RST_VAL(RSTV)) dut2 (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .di(di), .dout(dout2), .dout_valid(val2));
  rams_sp_be_pipe_neg #(.DEPTH(1024), .RDW_MODE(0), .OUT_REG(1), .RST_VAL(RSTV)) dut3 (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .di(di), .dout(dout3), .dout_valid(val3));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Expected outputs return to reset values and anything in flight is dropped.
  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      s1d[k] = RSTV;
      s1v[k] = 1'b0;
    end
    sbq.delete();
  endtask

  // Drive one access, predict every instance's outputs after the next
  // negedge, push the prediction, then step to just past that negedge.
  task automatic applyStimulus(input logic [3:0] w, input logic r, input logic [9:0] a,
                               input logic [31:0] d);
    exp_t        e;
    logic [31:0] oldW;
    logic [31:0] mrg;
    int          mode;
    bit          oor;
    we   = w;
    re   = r;
    addr = a;
    di   = d;
    e.d[3] = s1d[3];
    e.v[3] = s1v[3];
    for (int k = 0; k < 4; k++) begin
      mode = (k == 3) ? 0 : k;
      oor  = (k != 3) && (a >= 10'd1000);
      oldW = (k == 3) ? memP[a] : memS[a];
      mrg  = oldW;
      for (int b = 0; b < 4; b++) if (w[b]) mrg[b*8 +: 8] = d[b*8 +: 8];
      if (!r) begin
        s1v[k] = 1'b0;
      end else if (oor) begin
        s1d[k] = RSTV;
        s1v[k] = 1'b1;
      end else if (mode == 2 && w != 4'h0) begin
        s1v[k] = 1'b0;
      end else begin
        s1d[k] = (mode == 1) ? mrg : oldW;
        s1v[k] = 1'b1;
      end
      if (k < 3) begin
        e.d[k] = s1d[k];
        e.v[k] = s1v[k];
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (w[b]) begin
        if (a < 10'd1000) memS[a][b*8 +: 8] = d[b*8 +: 8];
        memP[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (doutA[k] !== RSTV || valA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_async dut%0d: dout=%h valid=%b, want dout=%h valid=0",
                 k, doutA[k], valA[k], RSTV);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_byte_lanes();
    stim_t tbl [4];
    exp_t  e;
    tbl[0] = '{4'hF, 1'b0, 10'd3, 32'h1122_3344};
    tbl[1] = '{4'b0101, 1'b0, 10'd3, 32'hAABB_CCDD};
    tbl[2] = '{4'h0, 1'b1, 10'd3, 32'h0};
    tbl[3] = '{4'h0, 1'b0, 10'd0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (doutA[k] !== e.d[k] || valA[k] !== e.v[k]) begin
          errors++;
          $display("[TB] FAIL byte_lanes dut%0d step %0d: dout=%h valid=%b, want dout=%h valid=%b",
                   k, i, doutA[k], valA[k], e.d[k], e.v[k]);
        end
      end
      if (i == 2) begin
        checks++;
        if (doutA[0] !== 32'h11BB_33DD || valA[0] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL byte_lanes_merge: dout=%h valid=%b, want 11bb33dd valid=1",
                   doutA[0], valA[0]);
        end
      end
      if (i == 3) begin
        checks++;
        if (doutA[3] !== 32'h11BB_33DD || valA[3] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL byte_lanes_pipe: dout=%h valid=%b, want 11bb33dd valid=1",
                   doutA[3], valA[3]);
        end
      end
    end
  endtask

  task automatic test_rdw();
    stim_t tbl [5];
    exp_t  e;
    tbl[0] = '{4'hF, 1'b0, 10'd7, 32'h0};
    tbl[1] = '{4'h0, 1'b1, 10'd3, 32'h0};
    tbl[2] = '{4'hF, 1'b1, 10'd7, 32'h5A5A_5A5A};
    tbl[3] = '{4'h0, 1'b1, 10'd7, 32'h0};
    tbl[4] = '{4'h0, 1'b0, 10'd0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (doutA[k] !== e.d[k] || valA[k] !== e.v[k]) begin
          errors++;
          $display("[TB] FAIL rdw dut%0d step %0d: dout=%h valid=%b, want dout=%h valid=%b",
                   k, i, doutA[k], valA[k], e.d[k], e.v[k]);
        end
      end
      if (i == 2) begin
        checks++;
        if (doutA[0] !== 32'h0 || valA[0] !== 1'b1 || doutA[1] !== 32'h5A5A_5A5A ||
            valA[1] !== 1'b1 || doutA[2] !== 32'h11BB_33DD || valA[2] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rdw_collide: rf=%h/%b wf=%h/%b nc=%h/%b, want 0/1 5a5a5a5a/1 11bb33dd/0",
                   doutA[0], valA[0], doutA[1], valA[1], doutA[2], valA[2]);
        end
      end
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (doutA[k] !== 32'h5A5A_5A5A || valA[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rdw_reread dut%0d: dout=%h valid=%b, want 5a5a5a5a valid=1",
                     k, doutA[k], valA[k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   nV;
    int   firstV;
    nV     = 0;
    firstV = -1;
    for (int i = 0; i < 11; i++) begin
      if (i < 4)      applyStimulus(4'hF, 1'b0, 10'(i), 32'hB0B0_0000 + 32'(i));
      else if (i < 8) applyStimulus(4'h0, 1'b1, 10'(i - 4), 32'h0);
      else            applyStimulus(4'h0, 1'b0, 10'd0, 32'h0);
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (doutA[k] !== e.d[k] || valA[k] !== e.v[k]) begin
          errors++;
          $display("[TB] FAIL back_to_back dut%0d step %0d: dout=%h valid=%b, want dout=%h valid=%b",
                   k, i, doutA[k], valA[k], e.d[k], e.v[k]);
        end
      end
      if (valA[3] === 1'b1) begin
        if (firstV < 0) firstV = i;
        checks++;
        if (doutA[3] !== 32'hB0B0_0000 + 32'(nV)) begin
          errors++;
          $display("[TB] FAIL back_to_back_order beat %0d: dout=%h, want %h",
                   nV, doutA[3], 32'hB0B0_0000 + 32'(nV));
        end
        nV++;
      end
    end
    checks++;
    if (nV != 4 || firstV != 5) begin
      errors++;
      $display("[TB] FAIL back_to_back_latency: valid beats=%0d first at step %0d, want 4 beats first at step 5",
               nV, firstV);
    end
  endtask

  task automatic test_out_of_range();
    stim_t tbl [5];
    exp_t  e;
    tbl[0] = '{4'hF, 1'b0, 10'd10, 32'hC0FF_EE10};
    tbl[1] = '{4'hF, 1'b0, 10'd1010, 32'hBADB_AD00};
    tbl[2] = '{4'h0, 1'b1, 10'd1010, 32'h0};
    tbl[3] = '{4'h0, 1'b1, 10'd10, 32'h0};
    tbl[4] = '{4'h0, 1'b0, 10'd0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (doutA[k] !== e.d[k] || valA[k] !== e.v[k]) begin
          errors++;
          $display("[TB] FAIL out_of_range dut%0d step %0d: dout=%h valid=%b, want dout=%h valid=%b",
                   k, i, doutA[k], valA[k], e.d[k], e.v[k]);
        end
      end
      if (i == 2) begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (doutA[k] !== RSTV || valA[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_read dut%0d: dout=%h valid=%b, want deadbeef valid=1",
                     k, doutA[k], valA[k]);
          end
        end
      end
      if (i == 3) begin
        checks++;
        if (doutA[0] !== 32'hC0FF_EE10 || doutA[3] !== 32'hBADB_AD00) begin
          errors++;
          $display("[TB] FAIL oor_alias: addr10=%h pipe1010=%h, want c0ffee10 badbad00",
                   doutA[0], doutA[3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    applyStimulus(4'hF, 1'b0, 10'd5, 32'hCAFE_0005);
    e = sbq.pop_front();
    applyStimulus(4'h0, 1'b1, 10'd5, 32'h0);
    e = sbq.pop_front();
    checks++;
    if (doutA[0] !== e.d[0] || valA[0] !== e.v[0]) begin
      errors++;
      $display("[TB] FAIL reset_mid_preread: dout=%h valid=%b, want dout=%h valid=%b",
               doutA[0], valA[0], e.d[0], e.v[0]);
    end
    // Reset lands between edges while dut3 still has the read in flight;
    // a write is presented throughout to show it is blocked.
    we   = 4'hF;
    re   = 1'b1;
    addr = 10'd5;
    di   = 32'h0;
    rst  = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (doutA[k] !== RSTV || valA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_async dut%0d: dout=%h valid=%b, want dout=%h valid=0",
                 k, doutA[k], valA[k], RSTV);
      end
    end
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    we  = 4'h0;
    re  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) applyStimulus(4'h0, 1'b1, 10'd5, 32'h0);
      else        applyStimulus(4'h0, 1'b0, 10'd0, 32'h0);
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (doutA[k] !== e.d[k] || valA[k] !== e.v[k]) begin
          errors++;
          $display("[TB] FAIL reset_mid dut%0d step %0d: dout=%h valid=%b, want dout=%h valid=%b",
                   k, i, doutA[k], valA[k], e.d[k], e.v[k]);
        end
      end
      if (i == 0) begin
        checks++;
        if (valA !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL reset_mid_discard: valid=%b, want 0000", valA);
        end
      end
      if (i == 2) begin
        checks++;
        if (doutA[3] !== 32'hCAFE_0005 || valA[3] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL reset_mid_reread: dout=%h valid=%b, want cafe0005 valid=1",
                   doutA[3], valA[3]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    we     = 4'h0;
    re     = 1'b0;
    addr   = 10'd0;
    di     = 32'h0;
    modelReset();
    #1;
    $display("[TB] start");
    test_reset();
    test_byte_lanes();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
